ipf_lcu_feeder: RTL and testbench

- Sequencer that streams a 128x128 8-bit frame from the frame-buffer memory into the IPF filter core, one LCU at a time, in LCU raster order (x fastest).
- Fetches the per-LCU filter parameters from the parameter table and holds them stable on the core's config inputs for the whole LCU.
- Obeys the core's busy back-pressure and reports frame completion once the core raises finish.

---
 rtl/ipf_lcu_feeder_if.sv | 35 +++
 rtl/ipf_lcu_feeder.sv | 193 +++++++++++++++++++
 tb/tb_ipf_lcu_feeder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ipf_lcu_feeder_if.sv
// Bundle of the frame-buffer, parameter-table and IPF-core signals seen by the LCU feeder.
// The master side is the feeder; the slave side is the memories plus the filter core.
interface ipf_lcu_feeder_if;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_data;
    logic        par_rd;
    logic [5:0]  par_addr;
    logic [23:0] par_data;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        busy;
    logic        finish;

    modport master (
        output img_rd, img_addr, par_rd, par_addr, in_en, din,
               ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size,
        input  img_data, par_data, busy, finish
    );

    modport slave (
        input  img_rd, img_addr, par_rd, par_addr, in_en, din,
               ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size,
        output img_data, par_data, busy, finish
    );
endinterface

// File: rtl/ipf_lcu_feeder.sv
// Streams a square 8-bit frame into the IPF core LCU by LCU (raster order), fetching each
// LCU's filter parameters first and honouring the core's busy back-pressure.
module ipf_lcu_feeder #(
    parameter int IMG_W      = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cfg_lcu_size,
    output logic              done,
    ipf_lcu_feeder_if.master  bus
);
    localparam int CW   = $clog2(IMG_W);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, PREQ, PCAP, STREAM, WFIN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      size_reg, size_next;
    logic [2:0]      lx_reg, lx_next, ly_reg, ly_next;
    logic [5:0]      row_reg, row_next, col_reg, col_next;
    logic            fetch_done_reg, fetch_done_next;
    logic [11:0]     xfer_reg, xfer_next;
    logic [23:0]     par_reg, par_next;
    logic            done_reg, done_next;
    logic            inflight_reg;
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNTW-1:0] count_reg;
    logic [7:0]      fifo_mem [FIFO_DEPTH];

    logic [5:0]    n_m1;
    logic [2:0]    l_m1;
    logic [11:0]   nn_m1;
    logic [CW-1:0] base_y, base_x;
    logic          last_lcu, fifo_empty, pop, push, img_rd;

    // N-1, L-1 and N*N-1 for the latched size code (size_reg never holds 3)
    always_comb begin
        n_m1   = 6'((7'd16 << size_reg) - 7'd1);
        l_m1   = 3'((4'd8 >> size_reg) - 4'd1);
        nn_m1  = 12'((13'd256 << {size_reg, 1'b0}) - 13'd1);
        base_y = CW'(ly_reg) << (3'd4 + {1'b0, size_reg});
        base_x = CW'(lx_reg) << (3'd4 + {1'b0, size_reg});
    end

    assign last_lcu   = (lx_reg == l_m1) && (ly_reg == l_m1);
    assign fifo_empty = (count_reg == '0);
    assign pop        = !fifo_empty && !bus.busy;
    assign push       = inflight_reg;

    // A pop this cycle frees a slot, so the read can be issued now and still fit on return.
    assign img_rd = (state_reg == STREAM) && !fetch_done_reg &&
                    ((int'(count_reg) + int'(inflight_reg) - int'(pop)) < FIFO_DEPTH);

    assign bus.img_rd       = img_rd;
    assign bus.img_addr     = {base_y + CW'(row_reg), base_x + CW'(col_reg)};
    assign bus.par_rd       = (state_reg == PREQ);
    assign bus.par_addr     = {ly_reg, lx_reg};
    assign bus.in_en        = !fifo_empty;
    assign bus.din          = fifo_mem[rd_ptr_reg];
    assign bus.ipf_type     = par_reg[23:22];
    assign bus.ipf_band_pos = par_reg[21:17];
    assign bus.ipf_wo_class = par_reg[16];
    assign bus.ipf_offset   = par_reg[15:0];
    assign bus.lcu_x        = lx_reg;
    assign bus.lcu_y        = ly_reg;
    assign bus.lcu_size     = size_reg;
    assign done             = done_reg;

    always_comb begin
        state_next      = state_reg;
        size_next       = size_reg;
        lx_next         = lx_reg;
        ly_next         = ly_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        fetch_done_next = fetch_done_reg;
        xfer_next       = xfer_reg;
        par_next        = par_reg;
        done_next       = done_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    size_next       = (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
                    lx_next         = '0;
                    ly_next         = '0;
                    row_next        = '0;
                    col_next        = '0;
                    fetch_done_next = 1'b0;
                    xfer_next       = '0;
                    done_next       = 1'b0;
                    state_next      = PREQ;
                end
            end
            PREQ: state_next = PCAP;
            PCAP: begin
                par_next   = bus.par_data;
                state_next = STREAM;
            end
            STREAM: begin
                if (img_rd) begin
                    if (col_reg == n_m1) begin
                        col_next = '0;
                        if (row_reg == n_m1) fetch_done_next = 1'b1;
                        else                 row_next = row_reg + 6'd1;
                    end else begin
                        col_next = col_reg + 6'd1;
                    end
                end
                if (pop) begin
                    xfer_next = xfer_reg + 12'd1;
                    if (xfer_reg == nn_m1) begin
                        xfer_next       = '0;
                        row_next        = '0;
                        col_next        = '0;
                        fetch_done_next = 1'b0;
                        if (last_lcu) begin
                            state_next = WFIN;
                        end else begin
                            state_next = PREQ;
                            if (lx_reg == l_m1) begin
                                lx_next = '0;
                                ly_next = ly_reg + 3'd1;
                            end else begin
                                lx_next = lx_reg + 3'd1;
                            end
                        end
                    end
                end
            end
            WFIN: begin
                if (bus.finish) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            size_reg       <= '0;
            lx_reg         <= '0;
            ly_reg         <= '0;
            row_reg        <= '0;
            col_reg        <= '0;
            fetch_done_reg <= 1'b0;
            xfer_reg       <= '0;
            par_reg        <= '0;
            done_reg       <= 1'b0;
            inflight_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            size_reg       <= size_next;
            lx_reg         <= lx_next;
            ly_reg         <= ly_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            fetch_done_reg <= fetch_done_next;
            xfer_reg       <= xfer_next;
            par_reg        <= par_next;
            done_reg       <= done_next;
            inflight_reg   <= img_rd;
        end
    end

    // Skid FIFO: catches read data one cycle after img_rd; entries reset so din starts at 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= bus.img_data;
                wr_ptr_reg <= (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Scoreboard bench: a raster-order reference model queues expected reads, parameter fetches
// and pixel transfers; a negedge monitor pops and compares whatever the feeder presents.
module tb_ipf_lcu_feeder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] cfg_lcu_size = 2'd0;
    logic       done;

    ipf_lcu_feeder_if bus ();

    ipf_lcu_feeder #(.IMG_W(128), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_lcu_size (cfg_lcu_size),
        .done         (done),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pix;
        logic [23:0] par;
        logic [2:0]  lx;
        logic [2:0]  ly;
    } exp_t;

    exp_t        exp_q[$];
    logic [13:0] addr_q[$];
    logic [5:0]  paddr_q[$];
    logic [7:0]  frame [16384];
    logic [23:0] ptab [64];
    logic [1:0]  exp_size;
    bit          mon_en = 1'b0;
    bit          busy_rand = 1'b0;
    logic        busy_force = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory models: one-cycle registered read latency
    always @(posedge clk) begin
        if (bus.img_rd) bus.img_data <= frame[bus.img_addr];
        if (bus.par_rd) bus.par_data <= ptab[bus.par_addr];
    end

    initial begin
        bus.busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.busy = busy_rand ? 1'($urandom_range(0, 1)) : busy_force;
        end
    end

    exp_t       mon_e;
    logic       hold_v = 1'b0;
    logic [7:0] hold_din;

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            hold_v <= 1'b0;
        end else begin
            if (bus.img_rd) begin
                if (addr_q.size() == 0) chk("img_rd_extra", 32'(bus.img_rd), 32'd0);
                else chk("img_addr", 32'(bus.img_addr), 32'(addr_q.pop_front()));
            end
            if (bus.par_rd) begin
                if (paddr_q.size() == 0) chk("par_rd_extra", 32'(bus.par_rd), 32'd0);
                else chk("par_addr", 32'(bus.par_addr), 32'(paddr_q.pop_front()));
            end
            if (hold_v) begin
                chk("in_en_hold", 32'(bus.in_en), 32'd1);
                chk("din_hold", 32'(bus.din), 32'(hold_din));
            end
            if (bus.in_en && !bus.busy) begin
                if (exp_q.size() == 0) begin
                    chk("xfer_extra", 32'(bus.in_en), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("din", 32'(bus.din), 32'(mon_e.pix));
                    chk("params", 32'({bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class,
                                       bus.ipf_offset}), 32'(mon_e.par));
                    chk("lcu_xy", 32'({bus.lcu_x, bus.lcu_y}), 32'({mon_e.lx, mon_e.ly}));
                    chk("lcu_size", 32'(bus.lcu_size), 32'(exp_size));
                end
            end
            hold_v   <= bus.in_en && bus.busy;
            hold_din <= bus.din;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected fetch addresses and pixel stream in LCU raster order
    task automatic setup_frame(input logic [1:0] code, input bit ramp);
        int   eff;
        int   n;
        int   l;
        int   a;
        exp_t e;
        eff = (code == 2'd3) ? 2 : int'(code);
        n   = 16 << eff;
        l   = 8 >> eff;
        exp_size = 2'(eff);
        for (int i = 0; i < 16384; i++) frame[i] = ramp ? 8'(i) : 8'($urandom);
        for (int p = 0; p < 64; p++) ptab[p] = 24'($urandom);
        ptab[0] = 24'h9A5F3C;
        exp_q.delete();
        addr_q.delete();
        paddr_q.delete();
        for (int ly = 0; ly < l; ly++) begin
            for (int lx = 0; lx < l; lx++) begin
                paddr_q.push_back(6'(ly * 8 + lx));
                for (int r = 0; r < n; r++) begin
                    for (int c = 0; c < n; c++) begin
                        a = (ly * n + r) * 128 + lx * n + c;
                        addr_q.push_back(14'(a));
                        e.pix = frame[a];
                        e.par = ptab[ly * 8 + lx];
                        e.lx  = 3'(lx);
                        e.ly  = 3'(ly);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic pulse_start(input logic [1:0] code);
        cfg_lcu_size = code;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_cleared", 32'(done), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem"}, 32'({bus.img_rd, bus.img_addr, bus.par_rd, bus.par_addr}), 32'd0);
        chk({tag, "_par"}, 32'({bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class,
                                bus.ipf_offset}), 32'd0);
        chk({tag, "_core"}, 32'({bus.in_en, bus.din, bus.lcu_x, bus.lcu_y, bus.lcu_size,
                                 done}), 32'd0);
    endtask

    task automatic run_frame(input logic [1:0] code, input bit ramp, input bit rnd);
        int cyc;
        int total;
        setup_frame(code, ramp);
        total = exp_q.size();
        busy_rand = rnd;
        mon_en = 1'b1;
        pulse_start(code);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 60000) begin
            tick();
            cyc++;
        end
        chk("xfer_left", 32'(exp_q.size()), 32'd0);
        chk("rd_left", 32'(addr_q.size() + paddr_q.size()), 32'd0);
        busy_rand = 1'b0;
        bus.finish = 1'b1;
        chk("done_before_finish", 32'(done), 32'd0);
        tick();
        bus.finish = 1'b0;
        chk("done_after_finish", 32'(done), 32'd1);
        repeat (3) tick();
        chk("done_level", 32'(done), 32'd1);
        $display("frame size_code=%0d busy_random=%0d transfers=%0d cycles=%0d",
                 code, rnd, total, cyc);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.finish = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        run_frame(2'd0, 1'b1, 1'b0);
        run_frame(2'd2, 1'b0, 1'b0);
        run_frame(2'd1, 1'b1, 1'b1);

        // Size code 3 into the second LCU, then stall to fill the FIFO and reset mid-stream
        setup_frame(2'd3, 1'b0);
        mon_en = 1'b1;
        pulse_start(2'd3);
        cyc = 0;
        while (exp_q.size() > 3 * 4096 - 40 && cyc < 20000) begin
            tick();
            cyc++;
        end
        chk("lcu1_reached", 32'(exp_q.size() <= 3 * 4096 - 40), 32'd1);
        busy_force = 1'b1;
        repeat (6) tick();
        chk("stall_in_en", 32'(bus.in_en), 32'd1);
        mon_en = 1'b0;
        reset = 1'b1;
        #2;
        chk_zero("abort");
        tick();
        tick();
        reset = 1'b0;
        busy_force = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_after_abort", 32'({bus.img_rd, bus.par_rd, bus.in_en}), 32'd0);
        end
        $display("abort size_code=3 after %0d cycles", cyc);

        setup_frame(2'd0, 1'b1);
        mon_en = 1'b1;
        pulse_start(2'd0);
        cyc = 0;
        while (exp_q.size() > 16384 - 300 && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("restream_progress", 32'(exp_q.size() <= 16384 - 300), 32'd1);
        mon_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        $display("restream size_code=0 transfers=%0d", 16384 - exp_q.size());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
